layer2_output_collector: RTL and testbench

LAYER2_OUTPUT_COLLECTOR -- requirements
Module: layer2_output_collector

---
 rtl/layer2_output_collector_pkg.sv | 22 ++
 rtl/layer2_output_collector_ram.sv | 27 ++
 rtl/layer2_output_collector.sv | 144 ++++++++++++++
 tb/tb_layer2_output_collector.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/layer2_output_collector_pkg.sv
// Shared CNN definitions for the layer-2 output collector: default geometry,
// controller states and a width helper.
package layer2_output_collector_pkg;

  localparam int DEFAULT_DEPTH = 100;
  localparam int DEFAULT_CH    = 8;
  localparam int DEFAULT_W     = 8;
  localparam int MAX_CH        = 8;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    DRAIN,
    FLUSH
  } state_t;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int width_of(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/layer2_output_collector_ram.sv
// Simple dual-port frame buffer: one write port, one read port with a
// registered read that only updates when a read is requested.
module collector_ram
  import layer2_output_collector_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int DW    = DEFAULT_CH * DEFAULT_W,
  parameter int AW    = width_of(DEFAULT_DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic          re,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data
);

  logic [DW-1:0] mem [DEPTH];

  // NOTE: storage and read register carry no reset so this maps onto block RAM.
  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
    if (re) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/layer2_output_collector.sv
// Captures pooled layer-2 positions into a frame buffer, then serializes them
// channel by channel on a valid/ready stream once the frame ends.
module layer2_output_collector
  import layer2_output_collector_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int CH    = DEFAULT_CH,
  parameter int W     = DEFAULT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] in1,
  input  logic [W-1:0] in2,
  input  logic [W-1:0] in3,
  input  logic [W-1:0] in4,
  input  logic [W-1:0] in5,
  input  logic [W-1:0] in6,
  input  logic [W-1:0] in7,
  input  logic [W-1:0] in8,
  input  logic         maxflagin,
  input  logic         donein,
  output logic [W-1:0] dout,
  output logic         dout_valid,
  input  logic         dout_ready,
  output logic         dout_last,
  output logic         busy,
  output logic         overflow
);

  localparam int PW = width_of(DEPTH + 1);
  localparam int AW = width_of(DEPTH);
  localparam int CW = width_of(CH);
  localparam int DW = CH * W;
  localparam logic [PW-1:0] FULL    = PW'(DEPTH);
  localparam logic [CW-1:0] LAST_CH = CW'(CH - 1);

  state_t        state, next_state;
  logic [PW-1:0] wr_ptr, rd_entry;
  logic [CW-1:0] ch;
  logic          q_valid, loaded_all;
  logic [W-1:0]  samples [MAX_CH];
  logic [DW-1:0] wr_data, rd_data;
  logic          we, re, load, last_entry;
  logic [AW-1:0] rd_addr;

  always_comb begin
    samples[0] = in1; samples[1] = in2; samples[2] = in3; samples[3] = in4;
    samples[4] = in5; samples[5] = in6; samples[6] = in7; samples[7] = in8;
    wr_data = '0;
    for (int c = 0; c < CH; c++) wr_data[c*W +: W] = samples[c];
  end

  // q_valid: rd_data holds entry rd_entry; the next entry is fetched while its
  // predecessor's last channel loads, giving one sample per cycle.
  assign we         = (state == COLLECT) && maxflagin && (wr_ptr != FULL);
  assign last_entry = (rd_entry == wr_ptr - PW'(1));
  assign load       = (state == DRAIN) && q_valid && !loaded_all && (!dout_valid || dout_ready);
  assign re         = (state == DRAIN) && !loaded_all &&
                      (!q_valid || (load && ch == LAST_CH && !last_entry));
  assign rd_addr    = q_valid ? AW'(rd_entry + PW'(1)) : AW'(rd_entry);

  collector_ram #(.DEPTH(DEPTH), .DW(DW), .AW(AW)) u_ram (
    .clk     (clk),
    .we      (we),
    .wr_addr (AW'(wr_ptr)),
    .wr_data (wr_data),
    .re      (re),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  // NOTE: state and counters use non-blocking assignments so every register
  // samples pre-edge values; combinational blocks assign defaults first to avoid latches.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = COLLECT;
      COLLECT: if (donein) next_state = (wr_ptr == '0 && !maxflagin) ? FLUSH : DRAIN;
      DRAIN:   if (dout_valid && dout_ready && dout_last) next_state = FLUSH;
      FLUSH:   next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr     <= '0;
      rd_entry   <= '0;
      ch         <= '0;
      q_valid    <= 1'b0;
      loaded_all <= 1'b0;
      dout       <= '0;
      dout_valid <= 1'b0;
      dout_last  <= 1'b0;
      busy       <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      busy <= (next_state != IDLE);
      if (state == IDLE && start) overflow <= 1'b0;
      if (state == COLLECT && maxflagin) begin
        if (wr_ptr == FULL) overflow <= 1'b1;
        else                wr_ptr   <= wr_ptr + PW'(1);
      end
      if (state == DRAIN) begin
        if (re && !q_valid) q_valid <= 1'b1;
        if (load) begin
          dout       <= rd_data[ch*W +: W];
          dout_valid <= 1'b1;
          dout_last  <= last_entry && (ch == LAST_CH);
          if (ch == LAST_CH) begin
            ch <= '0;
            if (last_entry) begin
              loaded_all <= 1'b1;
              q_valid    <= 1'b0;
            end else begin
              rd_entry <= rd_entry + PW'(1);
            end
          end else begin
            ch <= ch + CW'(1);
          end
        end else if (dout_valid && dout_ready) begin
          dout_valid <= 1'b0;
          dout_last  <= 1'b0;
        end
      end
      if (state == FLUSH) begin
        wr_ptr     <= '0;
        rd_entry   <= '0;
        ch         <= '0;
        q_valid    <= 1'b0;
        loaded_all <= 1'b0;
        dout_valid <= 1'b0;
        dout_last  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_layer2_output_collector.sv
// Randomized frame-level bench: a queue of expected samples built from the
// strobes is compared against the serialized stream.
module tb_layer2_output_collector;

  localparam int DEPTH = 100;
  localparam int CH    = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] ins [8];
  logic       maxflagin = 1'b0;
  logic       donein = 1'b0;
  logic       dout_ready = 1'b0;
  logic [7:0] dout;
  logic       dout_valid, dout_last, busy, overflow;

  int n_tests = 0;
  int n_fail = 0;
  int cyc = 0;
  int got_count, valid_seen, first_valid_cyc, done_cyc;
  logic [7:0] exp_q [$];
  bit         mon_en = 1'b0;
  bit         stall_pending = 1'b0;
  logic [7:0] prev_dout;
  logic       prev_last;

  layer2_output_collector dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .in1        (ins[0]),
    .in2        (ins[1]),
    .in3        (ins[2]),
    .in4        (ins[3]),
    .in5        (ins[4]),
    .in6        (ins[5]),
    .in7        (ins[6]),
    .in8        (ins[7]),
    .maxflagin  (maxflagin),
    .donein     (donein),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .dout_last  (dout_last),
    .busy       (busy),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Stream monitor: transfers happen on the edge after a negedge that sees valid && ready.
  always @(negedge clk) begin
    if (mon_en && rst) begin
      if (stall_pending) begin
        check("stall_dout", dout, prev_dout);
        check("stall_valid", dout_valid, 1);
        check("stall_last", dout_last, prev_last);
      end
      if (dout_valid) begin
        valid_seen++;
        if (first_valid_cyc < 0) first_valid_cyc = cyc;
      end
      if (dout_valid && dout_ready) begin
        check("sample_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          check("dout", dout, exp_q.pop_front());
          check("dout_last", dout_last, exp_q.size() == 0);
        end
        got_count++;
      end
      stall_pending = dout_valid && !dout_ready;
      prev_dout     = dout;
      prev_last     = dout_last;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_outputs_clear(input string tag);
    check({tag, "_dout"}, dout, 0);
    check({tag, "_valid"}, dout_valid, 0);
    check({tag, "_last"}, dout_last, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_overflow"}, overflow, 0);
  endtask

  // n strobes; abort_at >= 0 pulls reset once that many samples have been taken.
  task automatic run_frame(input int n, input bit rnd_data, input bit rnd_ready,
                           input bit done_with_last, input int abort_at);
    int k;
    logic [7:0] v;
    // Stray strobe while idle must not be captured.
    for (int c = 0; c < 8; c++) ins[c] = 8'($urandom_range(0, 255));
    maxflagin = 1'b1;
    tick();
    maxflagin = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("start_clears_overflow", overflow, 0);
    exp_q.delete();
    got_count = 0;
    valid_seen = 0;
    first_valid_cyc = -1;
    done_cyc = -1;
    stall_pending = 1'b0;
    mon_en = 1'b1;
    dout_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    for (int p = 0; p < n; p++) begin
      for (int c = 0; c < 8; c++) begin
        v = rnd_data ? 8'($urandom_range(0, 255)) : 8'(p + c);
        ins[c] = v;
        if (p < DEPTH && c < CH) exp_q.push_back(v);
      end
      maxflagin = 1'b1;
      donein = done_with_last && (p == n - 1);
      tick();
      if (donein) done_cyc = cyc;
      maxflagin = 1'b0;
      donein = 1'b0;
      if (rnd_data) repeat ($urandom_range(0, 2)) tick();
    end
    if (!(done_with_last && n > 0)) begin
      // Start while collecting is ignored and must not clear overflow.
      start = 1'b1;
      tick();
      start = 1'b0;
      donein = 1'b1;
      tick();
      done_cyc = cyc;
      donein = 1'b0;
    end
    k = 0;
    while (busy && k < 6000) begin
      if (abort_at >= 0 && got_count >= abort_at) break;
      dout_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      tick();
      k++;
    end
    if (abort_at >= 0) begin
      check("abort_reached", got_count, abort_at);
      check("abort_overflow_before", overflow, n > DEPTH);
      mon_en = 1'b0;
      #2 rst = 1'b0;
      #1 check_outputs_clear("abort");
      @(negedge clk);
      rst = 1'b1;
      exp_q.delete();
      tick();
      check("abort_idle_busy", busy, 0);
      return;
    end
    check("drain_timeout", k < 6000, 1);
    check("busy_end", busy, 0);
    check("sample_count", got_count, ((n > DEPTH) ? DEPTH : n) * CH);
    check("samples_left", exp_q.size(), 0);
    check("overflow_end", overflow, n > DEPTH);
    if (n > 0) check("first_valid_latency", first_valid_cyc - done_cyc, 2);
    if (n > 0 && !rnd_ready) check("no_bubbles", valid_seen, got_count);
    if (n == 0) begin
      check("empty_no_valid", valid_seen, 0);
      check("empty_return", k <= 2, 1);
    end
  endtask

  initial begin
    for (int c = 0; c < 8; c++) ins[c] = '0;
    #2 rst = 1'b0;
    #6 check_outputs_clear("reset");
    @(negedge clk);
    rst = 1'b1;
    tick();
    run_frame(100, 1'b0, 1'b0, 1'b1, -1);  // full frame, pattern p+c
    run_frame(100, 1'b1, 1'b1, 1'b0, -1);  // random data, backpressure
    run_frame(3,   1'b0, 1'b0, 1'b0, -1);  // short frame
    run_frame(0,   1'b0, 1'b0, 1'b0, -1);  // empty frame
    run_frame(101, 1'b1, 1'b1, 1'b0, -1);  // overflow, 101st dropped
    run_frame(101, 1'b0, 1'b1, 1'b0, 50);  // reset mid-drain
    run_frame(100, 1'b1, 1'b0, 1'b1, -1);  // normal frame after reset
    for (int i = 0; i < 3; i++)
      run_frame($urandom_range(1, DEPTH), 1'b1, 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), -1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
